// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, computed LSB-first one bit per clock
// through a single full-subtractor cell. Operations are issued with start and retired with done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bf,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bf_q;

    logic             d_bit;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs; the new bit enters the result at the MSB
    // so after WIDTH shifts the result register holds the difference in natural order.
    always_comb begin
        d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Handshake: start is accepted only in IDLE (no queuing, ignored otherwise); done is a
    // one-cycle pulse WIDTH+1 cycles after acceptance, and diff/bf hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q  <= res_d;
                        bf_q    <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign diff    = diff_q;
    assign bf      = bf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: table-driven directed vectors, hand-written multi-cycle
// corner sequences, and a randomized loop checked against an expected-result queue.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bf;
    logic [1:0]   state_o;

    int n_checks;
    int n_fail;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_bf;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bf      (bf),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op from the IDLE state and follows it to completion, checking the
    // busy window, done latency, result hold during the op and the popped result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W:0] exp, input string name);
        logic [W:0] prev;
        logic [W:0] want;
        int busy_cnt;
        int done_k;
        int overlap;
        prev     = {bf, diff};
        busy_cnt = 0;
        done_k   = 0;
        overlap  = 0;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(exp);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check({name, " hold"}, 32'({bf, diff}), 32'(prev));
            end
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({name, " latency"}, 32'(done_k), 32'(W + 1));
        check({name, " overlap"}, 32'(overlap), 32'd0);
        want = exp_q.pop_front();
        check({name, " result"}, 32'({bf, diff}), 32'(want));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_n;
        int overlap;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   model;

        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'hA7, 8'h24, 8'h83, 1'b0};
        vecs[2] = '{8'h24, 8'hA7, 8'h7D, 1'b1};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{8'h01, 8'h00, 8'h01, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[7] = '{8'h80, 8'h01, 8'h7F, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bf", 32'(bf), 32'd0);
        check("reset state", 32'(state_o), 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, {vecs[i].exp_bf, vecs[i].exp_diff},
                   $sformatf("vec%0d", i));

        // start held high for 30 cycles: back-to-back ops every WIDTH+2 cycles
        @(negedge clk);
        a       = 8'h80;
        b       = 8'h01;
        start   = 1'b1;
        done_n  = 0;
        overlap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) begin
                done_n++;
                check("held_start latency", 32'(k), 32'(9 + 10 * (done_n - 1)));
                check("held_start result", 32'({bf, diff}), 32'({1'b0, 8'h7F}));
            end
            if (k == 30) start = 1'b0;
        end
        check("held_start count", 32'(done_n), 32'd3);
        check("held_start overlap", 32'(overlap), 32'd0);

        // start pulses while busy and in DONE, with operand changes: all ignored
        @(negedge clk);
        a      = 8'h5A;
        b      = 8'h3C;
        start  = 1'b1;
        done_n = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                check("ignore latency", 32'(k), 32'd9);
                check("ignore result", 32'({bf, diff}), 32'({1'b0, 8'h1E}));
            end
            case (k)
                1: start = 1'b0;
                3: begin a = 8'h11; b = 8'h22; start = 1'b1; end
                4: begin
                    start = 1'b0;
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                end
                9:  start = 1'b1;
                10: start = 1'b0;
                default: ;
            endcase
        end
        check("ignore count", 32'(done_n), 32'd1);

        // Reset in the 4th SHIFT cycle aborts the op
        @(negedge clk);
        a      = 8'hFF;
        b      = 8'h01;
        start  = 1'b1;
        done_n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (k == 1) start = 1'b0;
            if (k == 4) begin
                check("abort busy_before", 32'(busy), 32'd1);
                rst = 1'b1;
            end
            if (k == 5) begin
                check("abort busy", 32'(busy), 32'd0);
                check("abort diff", 32'(diff), 32'd0);
                check("abort bf", 32'(bf), 32'd0);
                check("abort state", 32'(state_o), 32'd0);
                rst = 1'b0;
            end
        end
        check("abort no_done", 32'(done_n), 32'd0);
        run_op(8'hA7, 8'h24, {1'b0, 8'h83}, "after_abort");

        // Randomized ops against the unsigned subtract model
        for (int i = 0; i < 1000; i++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            model = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, model, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
